// File: rtl/input_debouncer.sv
// Synchronises and debounces one raw async input into a clean level plus rise/fall strobes.
// Latency: o/rise/fall update STABLE_CYCLES+2 edges after the input change is first sampled.
// Backpressure: none; this block is a free-running level filter with no handshake.
module input_debouncer #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i,
    output logic o,
    output logic rise,
    output logic fall,
    output logic busy
);

    if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255) begin : g_bad_stable_cycles
        $error("input_debouncer: STABLE_CYCLES must be in 2..255");
    end

    localparam logic [7:0] LAST_CNT = 8'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE_LOW,
        CHK_HIGH,
        IDLE_HIGH,
        CHK_LOW
    } state_t;

    logic       s1;
    logic       s2;
    state_t     state_q;
    state_t     state_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       o_d;
    logic       rise_d;
    logic       fall_d;

    // Two-flop synchroniser; nothing downstream looks at s1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= i;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE_LOW;
            cnt_q   <= 8'd0;
            o       <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            o       <= o_d;
            rise    <= rise_d;
            fall    <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        o_d     = o;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            IDLE_LOW: begin
                if (s2) begin
                    state_d = CHK_HIGH;
                    cnt_d   = 8'd1;
                end else begin
                    cnt_d = 8'd0;
                end
            end
            CHK_HIGH: begin
                if (!s2) begin
                    state_d = IDLE_LOW;
                    cnt_d   = 8'd0;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = IDLE_HIGH;
                    o_d     = 1'b1;
                    rise_d  = 1'b1;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            IDLE_HIGH: begin
                if (!s2) begin
                    state_d = CHK_LOW;
                    cnt_d   = 8'd1;
                end else begin
                    cnt_d = 8'd0;
                end
            end
            CHK_LOW: begin
                // A single cycle back at the old level discards the count.
                if (s2) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = 8'd0;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = IDLE_LOW;
                    o_d     = 1'b0;
                    fall_d  = 1'b1;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE_LOW;
                cnt_d   = 8'd0;
            end
        endcase
    end

    assign busy = (state_q == CHK_HIGH) || (state_q == CHK_LOW);

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer at STABLE_CYCLES = 4, 2 and 255.
module tb_input_debouncer;

    logic clk = 1'b0;
    logic rst_n;
    logic i_a, i_b, i_c;
    logic o_a, rise_a, fall_a, busy_a;
    logic o_b, rise_b, fall_b, busy_b;
    logic o_c, rise_c, fall_c, busy_c;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    input_debouncer #(.STABLE_CYCLES(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .i(i_a),
        .o(o_a), .rise(rise_a), .fall(fall_a), .busy(busy_a)
    );
    input_debouncer #(.STABLE_CYCLES(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .i(i_b),
        .o(o_b), .rise(rise_b), .fall(fall_b), .busy(busy_b)
    );
    input_debouncer #(.STABLE_CYCLES(255)) dut_c (
        .clk(clk), .rst_n(rst_n), .i(i_c),
        .o(o_c), .rise(rise_c), .fall(fall_c), .busy(busy_c)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_rise;
        int n_fall;
        logic [7:0] busy_tbl;

        rst_n = 1'b0;
        i_a = 1'b0; i_b = 1'b0; i_c = 1'b0;
        #12;
        chk("reset_a", {o_a, rise_a, fall_a, busy_a}, 4'b0000);
        chk("reset_b", {o_b, rise_b, fall_b, busy_b}, 4'b0000);
        chk("reset_c", {o_c, rise_c, fall_c, busy_c}, 4'b0000);
        tick();
        rst_n = 1'b1;

        // Idle low for 20 cycles
        for (int e = 0; e < 20; e++) begin
            tick();
            chk("idle_low", {o_a, rise_a, fall_a, busy_a}, 4'b0000);
        end

        // Bounce: 1 x2, 0 x1, 1 x2, then 0; o must never move
        busy_tbl = 8'b0110_1100; // bit e = expected busy after edge e (e=0..7)
        i_a = 1'b1; tick(); chk("bnc_busy0", busy_a, busy_tbl[0]);
        tick();                  chk("bnc_busy1", busy_a, busy_tbl[1]);
        i_a = 1'b0; tick();      chk("bnc_busy2", busy_a, busy_tbl[2]);
        i_a = 1'b1; tick();      chk("bnc_busy3", busy_a, busy_tbl[3]);
        tick();                  chk("bnc_busy4", busy_a, busy_tbl[4]);
        i_a = 1'b0;
        for (int e = 5; e < 10; e++) begin
            tick();
            chk("bnc_busy", busy_a, (e < 8) ? {31'd0, busy_tbl[e]} : 32'd0);
            chk("bnc_out", {o_a, rise_a, fall_a}, 3'b000);
        end

        // Clean rise: busy E2..E4, o/rise at E5, rise gone at E6
        i_a = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            tick();
            chk("rise_busy", busy_a, (e >= 2 && e <= 4) ? 32'd1 : 32'd0);
            chk("rise_o", o_a, (e >= 5) ? 32'd1 : 32'd0);
            chk("rise_strobe", rise_a, (e == 5) ? 32'd1 : 32'd0);
            chk("rise_nofall", fall_a, 1'b0);
        end

        // Reset in the middle of CHK_LOW
        i_a = 1'b0;
        for (int e = 0; e <= 3; e++) tick();
        chk("chklow_busy", {o_a, busy_a}, 2'b11);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_out", {o_a, rise_a, fall_a, busy_a}, 4'b0000);
        i_a = 1'b1;
        tick();
        tick();
        chk("inrst_out", {o_a, rise_a, fall_a, busy_a}, 4'b0000);
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            chk("rel_o", o_a, (e >= 6) ? 32'd1 : 32'd0);
            chk("rel_rise", rise_a, (e == 6) ? 32'd1 : 32'd0);
        end

        // STABLE_CYCLES = 2: up at E3, down 4 edges after falling sample
        n_rise = 0;
        n_fall = 0;
        i_b = 1'b1;
        for (int e = 0; e < 10; e++) begin
            tick();
            n_rise += int'(rise_b);
            n_fall += int'(fall_b);
            if (e == 2) chk("sc2_o_e2", o_b, 1'b0);
            if (e == 3) chk("sc2_o_e3", {o_b, rise_b}, 2'b11);
        end
        i_b = 1'b0;
        for (int e = 0; e < 8; e++) begin
            tick();
            n_rise += int'(rise_b);
            n_fall += int'(fall_b);
            chk("sc2_nboth", rise_b & fall_b, 1'b0);
            if (e == 2) chk("sc2_o_f2", o_b, 1'b1);
            if (e == 3) chk("sc2_o_f3", {o_b, fall_b}, 2'b01);
        end
        chk("sc2_nrise", n_rise, 1);
        chk("sc2_nfall", n_fall, 1);

        // STABLE_CYCLES = 255: o at E256, count peaks at 254
        i_c = 1'b1;
        for (int e = 0; e <= 256; e++) begin
            tick();
            if (e == 255) begin
                chk("sc255_cnt", dut_c.cnt_q, 8'd254);
                chk("sc255_e255", {o_c, busy_c}, 2'b01);
            end
        end
        chk("sc255_e256", {o_c, rise_c, busy_c}, 3'b110);
        chk("sc255_cnt0", dut_c.cnt_q, 8'd0);
        tick();
        chk("sc255_e257", {o_c, rise_c}, 2'b10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
